hazard_stall_ctrl: RTL and testbench

- Decode-stage interlock controller for the non-forwarding 5-stage pipeline.
- Tracks the destination-register tags of in-flight writers in ID/EX, EX/MEM and MEM/WB.
- Compares the decoding instruction's sources against those tags and drives stall and bubble.
- Sits between decode and the ID/EX pipeline register; it owns the in-flight tag pipeline.

---
 rtl/hazard_stall_ctrl_pkg.sv | 23 ++
 rtl/hazard_tag_pipe.sv | 27 ++
 rtl/hazard_stall_ctrl.sv | 70 +++++++
 tb/tb_hazard_stall_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the decode-stage interlock controller.
// The in-flight tag is {valid, register number}; the NOP tag never matches.
package hazard_stall_ctrl_pkg;

  localparam int DEF_REG_W = 3;
  localparam int DEF_CNT_W = 16;

  localparam int IDX_IDEX  = 0;
  localparam int IDX_EXMEM = 1;
  localparam int IDX_MEMWB = 2;

  typedef struct packed {
    logic                 valid;
    logic [DEF_REG_W-1:0] rnum;
  } tag_t;

  localparam tag_t TAG_NOP = '{valid: 1'b0, rnum: '0};

  function automatic logic tag_hit(input tag_t t, input logic [DEF_REG_W-1:0] r);
    return t.valid && (t.rnum == r);
  endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Three-stage shift register of in-flight destination tags (ID/EX -> EX/MEM -> MEM/WB).
// Advances every edge; a bubble loads the NOP tag into ID/EX.
module hazard_tag_pipe
  import hazard_stall_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bubble,
  input  tag_t id_tag,
  output tag_t tag_idex,
  output tag_t tag_exmem,
  output tag_t tag_memwb
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_idex  <= TAG_NOP;
      tag_exmem <= TAG_NOP;
      tag_memwb <= TAG_NOP;
    end else begin
      tag_memwb <= tag_exmem;
      tag_exmem <= tag_idex;
      tag_idex  <= bubble ? TAG_NOP : id_tag;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode interlock for the non-forwarding 5-stage pipe: stalls ID while any
// source register is still owned by a writer in ID/EX, EX/MEM or MEM/WB.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [REG_W-1:0] tag_idex,
  output logic [REG_W-1:0] tag_exmem,
  output logic [REG_W-1:0] tag_memwb,
  output logic [2:0]       tag_v,
  output logic [CNT_W-1:0] stall_cnt
);

  tag_t id_tag;
  tag_t t_idex, t_exmem, t_memwb;
  logic hit_rs, hit_rt, hazard;

  assign id_tag = '{valid: id_wr, rnum: id_rd};

  hazard_tag_pipe u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .bubble    (bubble),
    .id_tag    (id_tag),
    .tag_idex  (t_idex),
    .tag_exmem (t_exmem),
    .tag_memwb (t_memwb)
  );

  // No write-through in the register file, so MEM/WB still blocks a read.
  always_comb begin
    hit_rs = id_rs_used &&
             (tag_hit(t_idex, id_rs) || tag_hit(t_exmem, id_rs) || tag_hit(t_memwb, id_rs));
    hit_rt = id_rt_used &&
             (tag_hit(t_idex, id_rt) || tag_hit(t_exmem, id_rt) || tag_hit(t_memwb, id_rt));
    hazard = id_valid && !flush && (hit_rs || hit_rt);
    stall  = hazard;
    bubble = hazard || flush || !id_valid;
  end

  assign tag_idex  = t_idex.rnum;
  assign tag_exmem = t_exmem.rnum;
  assign tag_memwb = t_memwb.rnum;
  assign tag_v[IDX_IDEX]  = t_idex.valid;
  assign tag_v[IDX_EXMEM] = t_exmem.valid;
  assign tag_v[IDX_MEMWB] = t_memwb.valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; a second instance with a 4-bit
// counter shares the inputs so saturation can be reached quickly.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       id_rs_used, id_rt_used, id_wr, flush;

  logic        stall, bubble;
  logic [2:0]  tag_idex, tag_exmem, tag_memwb, tag_v;
  logic [15:0] stall_cnt;

  logic        stall4, bubble4;
  logic [2:0]  tag_idex4, tag_exmem4, tag_memwb4, tag_v4;
  logic [3:0]  stall_cnt4;

  int n_tests = 0;
  int n_fail  = 0;
  int n_st;

  hazard_stall_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_wr(id_wr), .flush(flush),
    .stall(stall), .bubble(bubble),
    .tag_idex(tag_idex), .tag_exmem(tag_exmem), .tag_memwb(tag_memwb),
    .tag_v(tag_v), .stall_cnt(stall_cnt)
  );

  hazard_stall_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_wr(id_wr), .flush(flush),
    .stall(stall4), .bubble(bubble4),
    .tag_idex(tag_idex4), .tag_exmem(tag_exmem4), .tag_memwb(tag_memwb4),
    .tag_v(tag_v4), .stall_cnt(stall_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs, input logic rsu,
                        input logic [2:0] rt, input logic rtu,
                        input logic [2:0] rd, input logic wr, input logic fl);
    id_valid = v;  id_rs = rs; id_rs_used = rsu;
    id_rt = rt;    id_rt_used = rtu;
    id_rd = rd;    id_wr = wr; flush = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  // writer of r5, 'gaps' independent non-writers, then a reader of rt=r5;
  // returns the number of stalled cycles and lets the reader issue.
  task automatic run_dep(input int gaps, output int n);
    drain();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
    tick();
    for (int g = 0; g < gaps; g++) begin
      set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0, 1'b0);
      tick();
    end
    set_id(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
    n = 0;
    while (stall && n < 6) begin
      tick();
      n++;
    end
    tick();
  endtask

  initial begin
    // 1: reset with a reader in ID
    rst = 1'b0;
    set_id(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
    check("rst_tag_v", tag_v, 3'b000);
    check("rst_stall", stall, 1'b0);
    check("rst_bubble", bubble, 1'b0);
    check("rst_cnt", stall_cnt, 0);
    rst = 1'b1;
    tick();
    check("first_idex_tag", tag_idex, 3'd2);
    check("first_tag_v", tag_v, 3'b001);

    // 2: back-to-back dependence, 3 stalls
    drain();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    check("t2_writer_nostall", stall, 1'b0);
    tick();
    set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t2_stall", stall, 1'b1);
      check("t2_bubble", bubble, 1'b1);
      tick();
    end
    check("t2_release_stall", stall, 1'b0);
    check("t2_release_bubble", bubble, 1'b0);
    check("t2_cnt", stall_cnt, 3);
    check("t2_pipe_empty", tag_v, 3'b000);
    tick();
    check("t2_issue_tag", tag_idex, 3'd7);
    check("t2_issue_v", tag_v, 3'b001);

    // 3: dependence distance 1..3 gaps
    run_dep(1, n_st);
    check("t3_gap1", n_st, 2);
    run_dep(2, n_st);
    check("t3_gap2", n_st, 1);
    run_dep(3, n_st);
    check("t3_gap3", n_st, 0);
    check("t3_cnt", stall_cnt, 6);

    // 4: flush beats hazard
    drain();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    check("t4_hazard_noflush", stall, 1'b1);
    set_id(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
    check("t4_flush_stall", stall, 1'b0);
    check("t4_flush_bubble", bubble, 1'b1);
    tick();
    check("t4_flush_tag_v", tag_v, 3'b100);
    check("t4_cnt", stall_cnt, 6);

    // 5: unused source and non-writing rd do not stall
    drain();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0);
    check("t5_unused_rs", stall, 1'b0);
    check("t5_unused_bubble", bubble, 1'b0);
    tick();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("t5_nowr_reader", stall, 1'b0);
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("t5_memwb_blocks", stall, 1'b1);

    // 6: saturation on the 4-bit counter, then reset mid-stall
    drain();
    rst = 1'b0;
    #1;
    check("t6_rst_cnt4", stall_cnt4, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) run_dep(0, n_st);
    run_dep(1, n_st);
    check("t6_cnt4_14", stall_cnt4, 14);
    check("t6_cnt16_14", stall_cnt, 14);
    drain();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    check("t6_cnt4_15", stall_cnt4, 4'd15);
    tick();
    tick();
    check("t6_cnt4_hold", stall_cnt4, 4'd15);
    check("t6_cnt16_17", stall_cnt, 17);
    check("t6_done_stall", stall, 1'b0);
    tick();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("t6_mid_stall", stall, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_async_stall", stall, 1'b0);
    check("t6_async_bubble", bubble, 1'b0);
    check("t6_async_cnt", stall_cnt, 0);
    check("t6_async_cnt4", stall_cnt4, 0);
    check("t6_async_tag_v", tag_v, 3'b000);
    rst = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
